// File: rtl/if_id_stage_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg_if
//   Handshake bundle between the fetch stage, the IF/ID pipeline register and
//   the decode stage.
//
//   Parameters
//     INS_W     instruction width in bits
//     PC_W      program-counter width in bits
//
//   Signals
//     in_valid  fetch presents an instruction
//     in_ins    fetched instruction
//     in_pc     PC of the fetched instruction
//     in_ready  stage accepts in_ins/in_pc on this falling edge
//     flush     squash every held entry (branch taken)
//     out_ready decode consumes the output entry on this falling edge
//     out_valid out_ins/out_pc hold a live instruction
//     out_ins   instruction to decode
//     out_pc    PC to decode
//     stall_cnt saturating count of edges where decode stalled
//
//   Modports
//     master    fetch/decode side (drives the requests, observes the register)
//     slave     the pipeline register itself
// ---------------------------------------------------------------------------
interface if_id_stage_reg_if #(
    parameter int INS_W = 32,
    parameter int PC_W  = 64
);
    logic             in_valid;
    logic [INS_W-1:0] in_ins;
    logic [PC_W-1:0]  in_pc;
    logic             in_ready;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [INS_W-1:0] out_ins;
    logic [PC_W-1:0]  out_pc;
    logic [15:0]      stall_cnt;

    modport master (
        output in_valid,
        output in_ins,
        output in_pc,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ins,
        input  out_pc,
        input  stall_cnt
    );

    modport slave (
        input  in_valid,
        input  in_ins,
        input  in_pc,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ins,
        output out_pc,
        output stall_cnt
    );
endinterface

// File: rtl/if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// if_id_stage_reg
//   IF/ID pipeline register with valid/ready handshakes on both sides, branch
//   flush, and a saturating decode-stall counter. All state changes on the
//   falling edge of clk; reset is asynchronous and active-high.
//
//   Parameters
//     INS_W     instruction width (default 32)
//     PC_W      program-counter width (default 64)
//     NOP_INS   bubble instruction shown when no entry is live (addi x0,x0,0)
//
//   Ports
//     clk       the only clock (falling-edge active)
//     reset     asynchronous active-high reset
//     bus       if_id_stage_reg_if.slave: in_valid/in_ins/in_pc/in_ready on
//               the fetch side, out_valid/out_ins/out_pc/out_ready on the
//               decode side, flush, stall_cnt
//
//   Build option
//     IF_ID_SKID_EN  when defined, a one-entry skid buffer sits behind the
//                    output entry (capacity 2) and in_ready comes straight
//                    from a flop. When undefined (default), capacity is 1 and
//                    in_ready = out_ready | ~out_valid, combinational.
// ---------------------------------------------------------------------------
module if_id_stage_reg #(
    parameter int               INS_W   = 32,
    parameter int               PC_W    = 64,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h00000013)
) (
    input logic              clk,
    input logic              reset,
    if_id_stage_reg_if.slave bus
);

    // Saturating increment for the stall counter: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Output entry (the one decode sees)
    logic             out_valid_q;
    logic             out_valid_d;
    logic [INS_W-1:0] out_ins_q;
    logic [INS_W-1:0] out_ins_d;
    logic [PC_W-1:0]  out_pc_q;
    logic [PC_W-1:0]  out_pc_d;
    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;

    logic in_ready_int;
    logic accept;
    logic retire;
    logic stall;

    // A flush squashes the simultaneous input as well, so it never counts as
    // an accepted transfer even though in_ready may read 1.
    assign accept = bus.in_valid & in_ready_int & ~bus.flush;
    assign retire = out_valid_q & bus.out_ready;
    assign stall  = out_valid_q & ~bus.out_ready & ~bus.flush;

    assign stall_cnt_d = stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;

`ifdef IF_ID_SKID_EN
    // Skid entry: holds the one instruction accepted while the output entry
    // is full and decode is stalled.
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [INS_W-1:0] skid_ins_q;
    logic [INS_W-1:0] skid_ins_d;
    logic [PC_W-1:0]  skid_pc_q;
    logic [PC_W-1:0]  skid_pc_d;
    logic             in_ready_q;
    logic             in_ready_d;

    // in_ready is the flop; the reset gate only forces it low while reset is
    // held, since the flop itself comes out of reset ready to accept.
    assign in_ready_int = in_ready_q & ~reset;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ins_d    = out_ins_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_ins_d   = skid_ins_q;
        skid_pc_d    = skid_pc_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            out_ins_d    = NOP_INS;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q) begin
            // Empty stage: the skid entry is necessarily empty too.
            if (accept) begin
                out_valid_d = 1'b1;
                out_ins_d   = bus.in_ins;
                out_pc_d    = bus.in_pc;
            end
        end else if (retire) begin
            if (skid_valid_q) begin
                // Skid entry is older than anything arriving now; in_ready
                // was low, so no input can be accepted on this edge.
                out_ins_d    = skid_ins_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_ins_d = bus.in_ins;
                out_pc_d  = bus.in_pc;
            end else begin
                out_valid_d = 1'b0;
                out_ins_d   = NOP_INS;
            end
        end else if (accept) begin
            // Output entry is stalled: park the new instruction.
            skid_valid_d = 1'b1;
            skid_ins_d   = bus.in_ins;
            skid_pc_d    = bus.in_pc;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(negedge clk) begin
        skid_ins_q <= skid_ins_d;
        skid_pc_q  <= skid_pc_d;
    end
`else
    assign in_ready_int = ~reset & (bus.out_ready | ~out_valid_q);

    always_comb begin
        out_valid_d = out_valid_q;
        out_ins_d   = out_ins_q;
        out_pc_d    = out_pc_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
            out_ins_d   = NOP_INS;
        end else if (accept) begin
            // Covers both a fill of the empty stage and a same-edge
            // retire-and-replace.
            out_valid_d = 1'b1;
            out_ins_d   = bus.in_ins;
            out_pc_d    = bus.in_pc;
        end else if (retire) begin
            // Bubble out; the PC is left as-is for debug visibility.
            out_valid_d = 1'b0;
            out_ins_d   = NOP_INS;
        end
    end
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ins_q   <= NOP_INS;
            out_pc_q    <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ins_q   <= out_ins_d;
            out_pc_q    <= out_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ins   = out_ins_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_reg
//   Self-checking bench for if_id_stage_reg. Inputs change just after the
//   rising edge; the DUT updates on the falling edge; outputs are sampled
//   just after the following rising edge. A queue of accepted instructions
//   acts as the reference: entries are pushed when an input is accepted and
//   popped when decode consumes the output entry.
// ---------------------------------------------------------------------------
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk;
    logic reset;

    if_id_stage_reg_if #(.INS_W(32), .PC_W(64)) bus ();

    if_id_stage_reg #(.INS_W(32), .PC_W(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [63:0] pc;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [31:0] eins;
        logic [63:0] epc;
        logic [15:0] est;
    } vec_t;

    ent_t        sb[$];
    logic [63:0] m_pc;
    logic [15:0] m_st;
    int          n_cmp;
    int          n_bad;
    vec_t        tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                         input logic fl, input logic ordy);
        bus.in_valid  = iv;
        bus.in_ins    = ins;
        bus.in_pc     = pc;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    // One falling edge with the currently driven inputs, reference update and
    // full output comparison afterwards.
    task automatic tick();
        logic exp_ready;
        logic acc;
        logic ret;
        ent_t e;
        #1;
        if (CAP == 2) exp_ready = (sb.size() < 2);
        else          exp_ready = (sb.size() == 0) || bus.out_ready;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});

        acc = bus.in_valid && exp_ready && !bus.flush;
        ret = (sb.size() > 0) && bus.out_ready && !bus.flush;
        if (!bus.flush && sb.size() > 0 && !bus.out_ready && m_st != 16'hFFFF)
            m_st = m_st + 16'd1;

        if (bus.flush) begin
            sb.delete();
        end else begin
            if (ret) begin
                e = sb.pop_front();
                chk("retired_ins", {32'd0, bus.out_ins}, {32'd0, e.ins});
                chk("retired_pc", bus.out_pc, e.pc);
            end
            if (acc) sb.push_back('{ins: bus.in_ins, pc: bus.in_pc});
        end
        if (sb.size() > 0) m_pc = sb[0].pc;

        @(negedge clk);
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, (sb.size() > 0)});
        chk("out_ins", {32'd0, bus.out_ins}, {32'd0, (sb.size() > 0) ? sb[0].ins : NOP});
        chk("out_pc", bus.out_pc, m_pc);
        chk("stall_cnt", {48'd0, bus.stall_cnt}, {48'd0, m_st});
    endtask

    // Asynchronous reset asserted between edges; checked before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        sb.delete();
        m_pc = 64'd0;
        m_st = 16'd0;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_ins", {32'd0, bus.out_ins}, {32'd0, NOP});
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_stall_cnt", {48'd0, bus.stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_pc  = 64'd0;
        m_st  = 16'd0;
        reset = 1'b1;
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);

        //            iv    ins           pc      fl    ordy  ev    eins          epc     est
        tbl[0]  = '{1'b1, 32'h00500093, 64'h0,  1'b0, 1'b1, 1'b1, 32'h00500093, 64'h0,  16'd0};
        tbl[1]  = '{1'b1, 32'h00a00113, 64'h4,  1'b0, 1'b1, 1'b1, 32'h00a00113, 64'h4,  16'd0};
        tbl[2]  = '{1'b0, 32'h0,        64'h0,  1'b0, 1'b0, 1'b1, 32'h00a00113, 64'h4,  16'd1};
        tbl[3]  = '{1'b0, 32'h0,        64'h0,  1'b0, 1'b0, 1'b1, 32'h00a00113, 64'h4,  16'd2};
        tbl[4]  = '{1'b0, 32'h0,        64'h0,  1'b0, 1'b1, 1'b0, NOP,          64'h4,  16'd2};
        tbl[5]  = '{1'b0, 32'h0,        64'h0,  1'b0, 1'b0, 1'b0, NOP,          64'h4,  16'd2};
        tbl[6]  = '{1'b1, 32'h002081b3, 64'h8,  1'b0, 1'b0, 1'b1, 32'h002081b3, 64'h8,  16'd2};
        tbl[7]  = '{1'b0, 32'h0,        64'h0,  1'b1, 1'b0, 1'b0, NOP,          64'h8,  16'd2};
        tbl[8]  = '{1'b1, 32'h40208233, 64'hc,  1'b0, 1'b1, 1'b1, 32'h40208233, 64'hc,  16'd2};
        tbl[9]  = '{1'b1, 32'h00000000, 64'h10, 1'b1, 1'b0, 1'b0, NOP,          64'hc,  16'd2};
        tbl[10] = '{1'b0, 32'h0,        64'h0,  1'b0, 1'b1, 1'b0, NOP,          64'hc,  16'd2};

        @(posedge clk);
        #1;
        do_reset();

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d_valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_ins", i), {32'd0, bus.out_ins}, {32'd0, tbl[i].eins});
            chk($sformatf("tbl%0d_pc", i), bus.out_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_stall", i), {48'd0, bus.stall_cnt}, {48'd0, tbl[i].est});
        end

        // Full stage stalled for 5 edges while fetch keeps offering
        do_reset();
        drive(1'b1, 32'h00100513, 64'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00200593, 64'h44, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
`ifndef IF_ID_SKID_EN
            chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
`endif
            tick();
            chk("stall_frozen_pc", bus.out_pc, 64'h40);
            chk("stall_frozen_ins", {32'd0, bus.out_ins}, 64'h00100513);
            chk("stall_frozen_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        chk("stall_cnt_5", {48'd0, bus.stall_cnt}, 64'd5);
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Two inputs against a stalled decode, then drain in order
        do_reset();
        drive(1'b1, 32'h00300613, 64'h10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00400693, 64'h14, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
`ifdef IF_ID_SKID_EN
        #1;
        chk("skid_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        chk("skid_head_pc", bus.out_pc, 64'h10);
`endif
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
        tick();
`ifdef IF_ID_SKID_EN
        chk("skid_second_pc", bus.out_pc, 64'h14);
        chk("skid_second_valid", {63'd0, bus.out_valid}, 64'd1);
`endif
        tick();
        chk("drained_valid", {63'd0, bus.out_valid}, 64'd0);

        // Flush together with a new input at PC 0x20
        drive(1'b1, 32'h00500713, 64'h18, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00600793, 64'h20, 1'b1, 1'b0);
        tick();
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_ins", {32'd0, bus.out_ins}, {32'd0, NOP});
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_0x20", {63'd0, (bus.out_valid && bus.out_pc == 64'h20)}, 64'd0);
        end

        // Randomised traffic against the reference queue
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            tick();
        end

        // Reset asserted between edges while full with a nonzero stall count
        drive(1'b1, 32'h00700813, 64'h30, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00800893, 64'h34, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        tick();
        tick();
        do_reset();
        drive(1'b1, 32'h00500093, 64'h0, 1'b0, 1'b1);
        tick();
        chk("post_reset_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("post_reset_ins", {32'd0, bus.out_ins}, 64'h00500093);

        // Long stall drives the counter into saturation
        do_reset();
        drive(1'b1, 32'h00900913, 64'h80, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        chk("stall_saturated", {48'd0, bus.stall_cnt}, 64'hFFFF);
        tick();
        chk("stall_no_wrap", {48'd0, bus.stall_cnt}, 64'hFFFF);
        drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
        tick();
        chk("sat_hold_after_retire", {48'd0, bus.stall_cnt}, 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
IF_ID_STAGE_REG -- requirements
Module: if_id_stage_reg

Interface
REQ-001 SHALL have parameter INS_W, default 32: instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 64: program-counter width in bits.
REQ-003 SHALL have parameter NOP_INS, default 32'h00000013: bubble instruction (addi x0,x0,0), INS_W bits.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its falling edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  the fetch stage presents an instruction.
REQ-007 SHALL have port in_ins  input  INS_W  fetched instruction.
REQ-008 SHALL have port in_pc  input  PC_W  PC of the fetched instruction.
REQ-009 SHALL have port in_ready  output  1  the stage accepts in_ins/in_pc this edge.
REQ-010 SHALL have port flush  input  1  squash all held entries (branch taken).
REQ-011 SHALL have port out_ready  input  1  the decode stage consumes the entry this edge.
REQ-012 SHALL have port out_valid  output  1  out_ins/out_pc hold a live instruction.
REQ-013 SHALL have port out_ins  output  INS_W  instruction to decode.
REQ-014 SHALL have port out_pc  output  PC_W  PC to decode.
REQ-015 SHALL have port stall_cnt  output  16  count of edges where decode stalls.

Function
REQ-016 SHALL transfer input on a falling edge only when in_valid and in_ready are both 1.
REQ-017 SHALL retire the output entry on a falling edge only when out_valid and out_ready are both 1.
REQ-018 SHALL have a latency of one falling edge from an accepted input to out_valid=1 when the stage is empty.
REQ-019 SHALL hold out_ins, out_pc and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL load out_ins with NOP_INS and keep out_pc unchanged when the entry retires and no new entry replaces it.
REQ-021 SHALL accept and retire on the same edge, with the new entry appearing on the outputs, when the stage is full and out_ready=1.
REQ-022 SHALL give flush priority on an edge: clear every valid bit, set out_ins to NOP_INS and discard any simultaneous input.
REQ-023 SHALL increment stall_cnt on each falling edge where out_valid=1 and out_ready=0, saturating at 16'hFFFF.
REQ-024 SHALL NOT count flush edges in stall_cnt.
REQ-025 SHALL never drop or duplicate an accepted instruction, absent flush.

Reset
REQ-026 SHALL, on reset=1, asynchronously force out_valid=0, out_ins=NOP_INS, out_pc=0, stall_cnt=0 and clear all internal valid bits.
REQ-027 SHALL abandon any transfer in progress when reset asserts mid-operation; no entry survives reset.
REQ-028 SHALL hold in_ready=0 while reset=1.
REQ-029 SHALL resume normal operation on the first falling edge after reset deasserts.

Configuration
REQ-030 SHALL support the macro IF_ID_SKID_EN, which selects one of two in_ready schemes.
REQ-031 SHALL, with IF_ID_SKID_EN defined, add a one-entry skid buffer:
- in_ready is registered and equals NOT skid_valid.
- An input accepted while the main entry is full and out_ready=0 goes to the skid buffer.
- The skid entry moves to the output on the next retire edge.
- Capacity is 2.
REQ-032 SHALL, without IF_ID_SKID_EN, have no skid buffer:
- in_ready = out_ready OR NOT out_valid, combinational.
- Capacity is 1.

Verification
REQ-033 SHALL pass: reset, then in_valid=1, in_ins=32'h00500093, in_pc=64'h0, out_ready=1 -> after 1 edge out_valid=1, out_ins=32'h00500093, out_pc=0.
REQ-034 SHALL pass: full stage, out_ready=0 for 5 edges -> outputs frozen, stall_cnt=5; without skid in_ready=0 throughout.
REQ-035 SHALL pass (IF_ID_SKID_EN): out_ready=0, two inputs at PC 0x10 and 0x14 -> in_ready=0 after the second; out_ready=1 -> 0x10 then 0x14 in order, no loss.
REQ-036 SHALL pass: flush=1 together with in_valid=1 (PC 0x20) -> next edge out_valid=0, out_ins=32'h00000013, and 0x20 never appears.
REQ-037 SHALL pass: force stall_cnt near 16'hFFFF through a long stall -> holds at 16'hFFFF and does not wrap.
REQ-038 SHALL pass: reset asserted between edges while full -> immediately out_valid=0, out_ins=NOP_INS, stall_cnt=0.
